// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display path: active-low hex patterns,
// blank pattern and segment bit positions ([6]=a ... [0]=g).
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Index = nibble value; bit order a..g, 0 = segment lit.
  localparam seg_t SEG_HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational 4-bit to active-low 7-segment decoder.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_HEX[nibble];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with double-buffered,
// frame-aligned updates. Define SEG_SCAN_LEADZERO_EN for leading-zero blanking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NDIG     = 8,
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] load_data,
  input  logic [NDIG-1:0]   blank_mask,
  output logic [NDIG-1:0]   dig_en_n,
  output logic [6:0]        seg_n
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned IW = $clog2(NDIG);

  logic [PW-1:0]     pre;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] disp;
  logic [4*NDIG-1:0] pending;
  logic              pend_full;
  logic              tick;
  logic              frame_end;
  logic              accept;
  logic [3:0]        nib;
  logic [6:0]        hex_seg;
  logic [NDIG-1:0]   lz;
  logic [NDIG-1:0]   blank_eff;
  logic [NDIG-1:0]   onehot;

  assign tick       = (pre == PW'(TICK_DIV - 1));
  assign frame_end  = tick && (idx == IW'(NDIG - 1));
  assign load_ready = !pend_full;
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
    end
  end

  // Transfer and accept are exclusive: ready is low whenever a transfer can happen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp      <= '0;
      pending   <= '0;
      pend_full <= 1'b0;
    end else if (frame_end && pend_full) begin
      disp      <= pending;
      pend_full <= 1'b0;
    end else if (accept) begin
      pending   <= load_data;
      pend_full <= 1'b1;
    end
  end

`ifdef SEG_SCAN_LEADZERO_EN
  logic run_zero;

  // Digit k>0 blanks when it and every more significant nibble are zero.
  always_comb begin
    lz       = '0;
    run_zero = 1'b1;
    for (int unsigned k = NDIG - 1; k >= 1; k--) begin
      run_zero = run_zero && (disp[4*k +: 4] == 4'h0);
      lz[k]    = run_zero;
    end
  end
`else
  always_comb begin
    lz = '0;
  end
`endif

  assign blank_eff = blank_mask | lz;
  assign onehot    = {{(NDIG-1){1'b0}}, 1'b1} << idx;
  assign nib       = disp[{idx, 2'b00} +: 4];

  hex7seg u_hex (
    .nibble (nib),
    .seg_n  (hex_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_en_n <= '1;
      seg_n    <= SEG_BLANK;
    end else if (blank_eff[idx]) begin
      dig_en_n <= '1;
      seg_n    <= SEG_BLANK;
    end else begin
      dig_en_n <= ~onehot;
      seg_n    <= hex_seg;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (NDIG=4, TICK_DIV=4, 16-cycle frames).
module tb_seg_scan_driver;

  localparam int unsigned NDIG     = 4;
  localparam int unsigned TICK_DIV = 4;
`ifdef SEG_SCAN_LEADZERO_EN
  localparam bit LZON = 1'b1;
`else
  localparam bit LZON = 1'b0;
`endif

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data  = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  dig_en_n;
  logic [6:0]  seg_n;

  always #5 clk = ~clk;

  seg_scan_driver #(.NDIG(NDIG), .TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .blank_mask (blank_mask),
    .dig_en_n   (dig_en_n),
    .seg_n      (seg_n)
  );

  typedef struct {
    logic [3:0] den;
    logic [6:0] seg;
    logic       rdy;
    int         tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [6:0] hexpat(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  task automatic check_rst(input string name);
    total++;
    if (dig_en_n !== 4'hF || seg_n !== 7'h7F || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s got den=%b seg=%b rdy=%b want den=1111 seg=1111111 rdy=1",
               name, dig_en_n, seg_n, load_ready);
    end
  endtask

  // Drives one frame (or its first 'stop' edges) and queues the expected
  // registered outputs after each edge. lzm lists digits blanked by leading zeros.
  task automatic run_frame(input int fid, input logic [15:0] word,
                           input logic [3:0] mask, input logic [3:0] lzm,
                           input int va_from, input int va_to, input int acc,
                           input logic [15:0] d1, input logic [15:0] d2,
                           input int stop);
    for (int k = 1; k <= stop; k++) begin
      exp_t       e;
      int         d;
      logic [3:0] eff;
      logic [3:0] nib;
      load_valid = (k >= va_from) && (k <= va_to);
      load_data  = (acc == 0 || k <= acc) ? d1 : d2;
      blank_mask = mask;
      d     = (k - 1) / 4;
      eff   = LZON ? (mask | lzm) : mask;
      nib   = 4'(word >> (4 * d));
      e.den = eff[d] ? 4'hF : ~(4'b0001 << d);
      e.seg = eff[d] ? 7'h7F : hexpat(nib);
      e.rdy = (k == 16) ? 1'b1 : ((acc != 0 && k >= acc) ? 1'b0 : 1'b1);
      e.tag = fid * 100 + k;
      q.push_back(e);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
  endtask

  // Monitor: after every clock edge taken out of reset, one expectation is due.
  initial begin
    logic s;
    exp_t e;
    forever begin
      @(posedge clk);
      s = !rst;
      @(negedge clk);
      if (s) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL underflow got den=%b seg=%b rdy=%b want queued entry",
                   dig_en_n, seg_n, load_ready);
        end else begin
          e = q.pop_front();
          if (dig_en_n !== e.den || seg_n !== e.seg || load_ready !== e.rdy) begin
            bad++;
            $display("FAIL slot tag=%0d got den=%b seg=%b rdy=%b want den=%b seg=%b rdy=%b",
                     e.tag, dig_en_n, seg_n, load_ready, e.den, e.seg, e.rdy);
          end
        end
      end
    end
  end

  initial begin
    int r;
    r = int'($urandom_range(2, 14));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_rst("reset_hold");
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame(0, 16'h0000, 4'b0000, 4'b1110, 1, 0, 0, 16'h0000, 16'h0000, 16);
    run_frame(1, 16'h0000, 4'b0000, 4'b1110, r, r, r, 16'h1A2F, 16'h1A2F, 16);
    run_frame(2, 16'h1A2F, 4'b0000, 4'b0000, 1, 0, 0, 16'h0000, 16'h0000, 16);
    run_frame(3, 16'h1A2F, 4'b0000, 4'b0000, 3, 16, 3, 16'h1111, 16'h2222, 16);
    run_frame(4, 16'h1111, 4'b0000, 4'b0000, 1, 1, 1, 16'h2222, 16'h2222, 16);
    run_frame(5, 16'h2222, 4'b0100, 4'b0000, 1, 0, 0, 16'h0000, 16'h0000, 16);
    run_frame(6, 16'h2222, 4'b0000, 4'b0000, 2, 2, 2, 16'h3333, 16'h3333, 9);

    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_rst("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_frame(10, 16'h0000, 4'b0000, 4'b1110, 1, 0, 0, 16'h0000, 16'h0000, 16);
    run_frame(11, 16'h0000, 4'b0000, 4'b1110, 5, 5, 5, 16'h0050, 16'h0050, 16);
    run_frame(12, 16'h0050, 4'b0000, 4'b1100, 7, 7, 7, 16'h0000, 16'h0000, 16);
    run_frame(13, 16'h0000, 4'b0000, 4'b1110, 1, 0, 0, 16'h0000, 16'h0000, 16);

    @(negedge clk); #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d entries left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
